judge_sel_mux: RTL and testbench
================================

// Module: judge_sel_mux
// PURPOSE
// - N-channel registered selector for per-mode judge words; generalises the two-channel mode-3/mode-4 judge selector.
// - The game mode register selects which source (player/AI/replay judge logic) drives the shared judge bus into move logic.
// - Adds a settle window that blanks the output after a mode change, a hold/freeze control, and an output-change strobe.
// - Sits between the per-mode judge generators and the board-move / display update logic.
// PARAMETERS
// - NUM_CH      2   number of judge source channels (>=1)
// - WIDTH       16  bits per judge word
// - MODE_W      4   width of mode input
// - MODE_BASE   3   mode code mapped to channel 0; channel k = MODE_BASE+k
// - SETTLE_CYC  2   zero-output cycles after entering/changing a valid mode; 0 = no blanking
// PORTS
// - clk        in   1               system clock; all logic on rising edge
// - rst        in   1               synchronous, active-high reset
// - mode       in   MODE_W          current game mode code
// - judge_in   in   NUM_CH*WIDTH    channel k at bits [k*WIDTH +: WIDTH]
// - hold       in   1               freeze judge_out while in PASS
// - judge_out  out  WIDTH           registered selected judge word
// - judge_chg  out  1               one-cycle pulse: judge_out changed on this edge
// - active     out  1               high while state==PASS
// - ch_idx     out  clog2(NUM_CH)   registered index of selected channel (0 when IDLE)
// BEHAVIOUR
// - Reset: state=IDLE, judge_out=0, judge_chg=0, active=0, ch_idx=0, cnt=0, mode_q=0.
// - Valid mode: MODE_BASE <= mode < MODE_BASE+NUM_CH (unsigned compare, no wrap); ch = mode-MODE_BASE.
// - States: IDLE, SETTLE, PASS. mode_q registers mode every edge.
// - Per-edge priority: rst > invalid mode > mode entry/change > settle countdown > hold > pass.
// - Invalid mode (any state): ->IDLE, judge_out<=0, ch_idx<=0.
// - Entry: valid mode and (state==IDLE or mode!=mode_q):
//   SETTLE_CYC==0 -> PASS, judge_out<=judge_in[ch] (1-cycle latency, legacy behaviour);
//   else -> SETTLE, cnt<=SETTLE_CYC-1, judge_out<=0. ch_idx<=ch.
// - SETTLE, same mode: cnt==0 -> PASS, judge_out<=judge_in[ch]; else cnt--, judge_out<=0.
//   => output is 0 for exactly SETTLE_CYC edges; input first sampled on edge SETTLE_CYC after change.
// - Mode change mid-SETTLE restarts the window (cnt reloaded); change to invalid aborts to IDLE.
// - PASS: hold=0 -> judge_out<=judge_in[ch] each edge; hold=1 -> judge_out retained.
// - hold is ignored in IDLE/SETTLE (blanking is not paused); hold never blocks mode entry.
// - judge_chg <= (next judge_out != judge_out); registered with judge_out, 0 at/after reset.
// - active <= (next state==PASS), aligned with judge_out.
// - Width: cnt width clog2(SETTLE_CYC+1) (min 1); mode subtraction done in MODE_W bits after range check.
// STRUCTURE
// - judge_pkg: state enum {IDLE,SETTLE,PASS}, default MODE_BASE/WIDTH constants, clog2 function.
// - Sub-module judge_chan_sel: combinational range check + index decode + WIDTH-bit N:1 mux -> {valid, ch, word}.
// - Top: mode_q reg, FSM + settle counter, output regs, change comparator.
// TESTING
// - Reset: rst=1 two cycles with mode=3, judge_in all 0xFFFF -> judge_out=0, chg=0, active=0 throughout.
// - Entry: SETTLE_CYC=2, mode 0->3, ch0=0x0004 -> out 0,0 on edges 1-2, 0x0004 on edge 3 with chg=1, active=1.
// - Switch: in PASS on ch0=0x0004, mode->4, ch1=0x0010 -> out 0 at next edge (chg=1), 0 again, then 0x0010, ch_idx=1.
// - Restart/abort: mode 3 then 4 one edge later -> window restarts (two more zero edges); mode=9 mid-SETTLE -> IDLE, active=0.
// - Hold: PASS ch0=0x0002, hold=1, ch0->0x0008 -> out stays 0x0002, chg=0; hold=0 -> 0x0008 next edge, chg=1 one cycle.
// - Legacy: SETTLE_CYC=0, mode=3 ch0=0x1234 -> out 0x1234 one edge later; mode=2/5/15 -> out 0; NUM_CH=4 mode=6 -> ch3.

Source files
------------

// File: rtl/judge_sel_mux_pkg.sv
// Shared definitions for the judge selector.
// - judge_state_e : selector FSM states (idle, settle/blanking, pass-through)
// - DefModeBase / DefWidth : default mode code of channel 0 and judge word width
// - clog2_min1 : ceil(log2(v)) clamped to at least 1, for sizing index/counter fields
package judge_sel_mux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StPass
    } judge_state_e;

    localparam int unsigned DefModeBase = 3;
    localparam int unsigned DefWidth    = 16;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/judge_sel_mux_chan_sel.sv
// Combinational channel decode for the judge selector.
// Ports:
// - i_mode     : current game mode code
// - i_judge_in : packed judge words, channel k at [k*WIDTH +: WIDTH]
// - o_valid    : mode maps to an existing channel
// - o_ch       : channel index (mode - MODE_BASE), meaningful only when o_valid
// - o_word     : judge word of channel o_ch
module judge_sel_mux_chan_sel
    import judge_sel_mux_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned MODE_W    = 4,
    parameter int unsigned MODE_BASE = DefModeBase,
    parameter int unsigned CH_W      = 1
) (
    input  logic [MODE_W-1:0]       i_mode,
    input  logic [NUM_CH*WIDTH-1:0] i_judge_in,
    output logic                    o_valid,
    output logic [CH_W-1:0]         o_ch,
    output logic [WIDTH-1:0]        o_word
);

    logic [31:0]       w_mode_ext;
    logic [MODE_W-1:0] w_diff;

    // Range check in 32 bits so MODE_BASE+NUM_CH cannot wrap inside MODE_W.
    assign w_mode_ext = 32'(i_mode);
    assign o_valid    = (w_mode_ext >= MODE_BASE) && (w_mode_ext < MODE_BASE + NUM_CH);
    assign w_diff     = i_mode - MODE_W'(MODE_BASE);
    assign o_ch       = w_diff[CH_W-1:0];

    always_comb begin
        o_word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (o_ch == CH_W'(k)) begin
                o_word = i_judge_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/judge_sel_mux.sv
// Registered N-channel judge word selector with post-mode-change blanking.
// Ports:
// - i_clk, i_rst  : clock, synchronous active-high reset
// - i_mode        : game mode; MODE_BASE+k selects channel k, anything else idles
// - i_judge_in    : packed judge words, channel k at [k*WIDTH +: WIDTH]
// - i_hold        : freeze o_judge_out while passing through
// - o_judge_out   : registered selected judge word (0 while idle or settling)
// - o_judge_chg   : one-cycle pulse when o_judge_out changed on this edge
// - o_active      : high while passing a channel through
// - o_ch_idx      : registered selected channel index (0 when idle)
module judge_sel_mux
    import judge_sel_mux_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned MODE_W     = 4,
    parameter int unsigned MODE_BASE  = DefModeBase,
    parameter int unsigned SETTLE_CYC = 2,
    localparam int unsigned CH_W      = clog2_min1(NUM_CH),
    localparam int unsigned CNT_W     = clog2_min1(SETTLE_CYC + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [MODE_W-1:0]       i_mode,
    input  logic [NUM_CH*WIDTH-1:0] i_judge_in,
    input  logic                    i_hold,
    output logic [WIDTH-1:0]        o_judge_out,
    output logic                    o_judge_chg,
    output logic                    o_active,
    output logic [CH_W-1:0]         o_ch_idx
);

    judge_state_e      r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [MODE_W-1:0] r_mode_q;
    logic [WIDTH-1:0]  r_judge_out, w_judge_d;
    logic [CH_W-1:0]   r_ch_idx, w_ch_d;
    logic              r_judge_chg, r_active;

    logic              w_valid;
    logic [CH_W-1:0]   w_ch;
    logic [WIDTH-1:0]  w_word;

    judge_sel_mux_chan_sel #(
        .NUM_CH    (NUM_CH),
        .WIDTH     (WIDTH),
        .MODE_W    (MODE_W),
        .MODE_BASE (MODE_BASE),
        .CH_W      (CH_W)
    ) u_chan_sel (
        .i_mode     (i_mode),
        .i_judge_in (i_judge_in),
        .o_valid    (w_valid),
        .o_ch       (w_ch),
        .o_word     (w_word)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_judge_d = r_judge_out;
        w_ch_d    = r_ch_idx;
        if (!w_valid) begin
            w_state_d = StIdle;
            w_judge_d = '0;
            w_ch_d    = '0;
        end else if (r_state == StIdle || i_mode != r_mode_q) begin
            // Entry or mode change: (re)start the blanking window.
            w_ch_d = w_ch;
            if (SETTLE_CYC == 0) begin
                w_state_d = StPass;
                w_judge_d = w_word;
            end else begin
                w_state_d = StSettle;
                w_cnt_d   = CNT_W'(SETTLE_CYC - 1);
                w_judge_d = '0;
            end
        end else if (r_state == StSettle) begin
            if (r_cnt == '0) begin
                w_state_d = StPass;
                w_judge_d = w_word;
            end else begin
                w_cnt_d   = r_cnt - CNT_W'(1);
                w_judge_d = '0;
            end
        end else if (!i_hold) begin
            w_judge_d = w_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_mode_q    <= '0;
            r_judge_out <= '0;
            r_judge_chg <= 1'b0;
            r_active    <= 1'b0;
            r_ch_idx    <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_mode_q    <= i_mode;
            r_judge_out <= w_judge_d;
            r_judge_chg <= (w_judge_d != r_judge_out);
            r_active    <= (w_state_d == StPass);
            r_ch_idx    <= w_ch_d;
        end
    end

    assign o_judge_out = r_judge_out;
    assign o_judge_chg = r_judge_chg;
    assign o_active    = r_active;
    assign o_ch_idx    = r_ch_idx;

endmodule

// File: tb/tb_judge_sel_mux.sv
// Scoreboard bench for judge_sel_mux: two instances driven by the same stimulus,
// u_dut0 (2 channels, 2-cycle settle) and u_dut1 (4 channels, no settle).
module tb_judge_sel_mux;

    typedef struct {
        logic [15:0] out;
        logic        chg;
        logic        active;
        logic [1:0]  ch;
    } exp_t;

    // Reference state: n counts edges since (and including) the entry edge.
    typedef struct {
        bit          idle;
        int          n;
        logic [3:0]  mode_q;
        logic [15:0] out;
        logic        chg;
        logic        active;
        logic [1:0]  ch;
    } mdl_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_mode;
    logic [63:0] i_judge;
    logic        i_hold;

    logic [15:0] out0, out1;
    logic        chg0, chg1, act0, act1;
    logic        ch0;
    logic [1:0]  ch1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    mdl_t m0, m1;

    always #5 i_clk = ~i_clk;

    judge_sel_mux #(
        .NUM_CH(2), .WIDTH(16), .MODE_W(4), .MODE_BASE(3), .SETTLE_CYC(2)
    ) u_dut0 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_mode      (i_mode),
        .i_judge_in  (i_judge[31:0]),
        .i_hold      (i_hold),
        .o_judge_out (out0),
        .o_judge_chg (chg0),
        .o_active    (act0),
        .o_ch_idx    (ch0)
    );

    judge_sel_mux #(
        .NUM_CH(4), .WIDTH(16), .MODE_W(4), .MODE_BASE(3), .SETTLE_CYC(0)
    ) u_dut1 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_mode      (i_mode),
        .i_judge_in  (i_judge),
        .i_hold      (i_hold),
        .o_judge_out (out1),
        .o_judge_chg (chg1),
        .o_active    (act1),
        .o_ch_idx    (ch1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_step(input mdl_t s, input int nch, input int settle,
                                      input logic rst, input logic [3:0] mode,
                                      input logic [63:0] jin, input logic hold);
        mdl_t        r;
        logic [15:0] nout;
        r = s;
        if (rst) begin
            r.idle = 1; r.n = 0; r.mode_q = '0; r.out = '0;
            r.chg = 1'b0; r.active = 1'b0; r.ch = '0;
            return r;
        end
        nout = s.out;
        if (int'(mode) < 3 || int'(mode) >= 3 + nch) begin
            r.idle = 1; r.n = 0; r.ch = '0; nout = '0;
        end else begin
            if (s.idle || mode != s.mode_q) begin
                r.idle = 0; r.n = 1;
            end else begin
                r.n = s.n + 1;
            end
            r.ch = 2'(int'(mode) - 3);
            if (r.n <= settle) nout = '0;
            else if (!(hold && r.n > settle + 1)) nout = jin[int'(r.ch)*16 +: 16];
        end
        r.chg    = (nout != s.out);
        r.out    = nout;
        r.active = !r.idle && (r.n > settle);
        r.mode_q = mode;
        return r;
    endfunction

    // Predict, push, clock, pop and compare.
    task automatic tick(input logic rst, input logic [3:0] mode, input logic [63:0] jin,
                        input logic hold);
        exp_t e;
        i_rst = rst; i_mode = mode; i_judge = jin; i_hold = hold;
        m0 = mdl_step(m0, 2, 2, rst, mode, jin, hold);
        m1 = mdl_step(m1, 4, 0, rst, mode, jin, hold);
        q0.push_back('{m0.out, m0.chg, m0.active, m0.ch});
        q1.push_back('{m1.out, m1.chg, m1.active, m1.ch});
        @(posedge i_clk);
        #1;
        e = q0.pop_front();
        check_eq("d0_out", 32'(out0), 32'(e.out));
        check_eq("d0_chg", 32'(chg0), 32'(e.chg));
        check_eq("d0_act", 32'(act0), 32'(e.active));
        check_eq("d0_ch",  32'(ch0),  32'(e.ch));
        e = q1.pop_front();
        check_eq("d1_out", 32'(out1), 32'(e.out));
        check_eq("d1_chg", 32'(chg1), 32'(e.chg));
        check_eq("d1_act", 32'(act1), 32'(e.active));
        check_eq("d1_ch",  32'(ch1),  32'(e.ch));
    endtask

    initial begin
        logic [63:0] jin;
        m0 = '{1, 0, 4'd0, 16'd0, 1'b0, 1'b0, 2'd0};
        m1 = m0;
        i_rst = 1'b1; i_mode = '0; i_judge = '0; i_hold = 1'b0;

        // Reset with a valid mode and all-ones inputs.
        tick(1'b1, 4'd3, {64{1'b1}}, 1'b0);
        tick(1'b1, 4'd3, {64{1'b1}}, 1'b0);
        check_eq("rst_out", 32'(out0), 32'h0);

        jin = {16'h0000, 16'h0000, 16'h0010, 16'h0004};
        tick(1'b0, 4'd0, jin, 1'b0);
        // Entry on channel 0: two blank edges then data.
        repeat (3) tick(1'b0, 4'd3, jin, 1'b0);
        check_eq("entry_out", 32'(out0), 32'h0004);
        check_eq("entry_act", 32'(act0), 32'h1);
        // Switch to channel 1.
        repeat (3) tick(1'b0, 4'd4, jin, 1'b0);
        check_eq("switch_out", 32'(out0), 32'h0010);
        check_eq("switch_ch", 32'(ch0), 32'h1);
        // Restart mid-settle, then abort with an invalid mode.
        tick(1'b0, 4'd3, jin, 1'b0);
        repeat (3) tick(1'b0, 4'd4, jin, 1'b0);
        tick(1'b0, 4'd3, jin, 1'b0);
        tick(1'b0, 4'd9, jin, 1'b0);
        check_eq("abort_act", 32'(act0), 32'h0);

        // Hold in pass.
        jin = {16'h0000, 16'h0000, 16'h0010, 16'h0002};
        repeat (3) tick(1'b0, 4'd3, jin, 1'b0);
        jin[15:0] = 16'h0008;
        repeat (2) tick(1'b0, 4'd3, jin, 1'b1);
        check_eq("hold_out", 32'(out0), 32'h0002);
        repeat (2) tick(1'b0, 4'd3, jin, 1'b0);
        check_eq("unhold_out", 32'(out0), 32'h0008);

        // Invalid modes and channel 3 of the wide, no-settle instance.
        jin = {16'hABCD, 16'h5555, 16'h0010, 16'h1234};
        tick(1'b0, 4'd2, jin, 1'b0);
        tick(1'b0, 4'd3, jin, 1'b0);
        check_eq("legacy_out", 32'(out1), 32'h1234);
        tick(1'b0, 4'd5, jin, 1'b0);
        tick(1'b0, 4'd15, jin, 1'b0);
        tick(1'b0, 4'd6, jin, 1'b0);
        check_eq("ch3_out", 32'(out1), 32'hABCD);
        check_eq("ch3_idx", 32'(ch1), 32'h3);

        // Random traffic; modes biased so channels stay selected for several edges.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] md;
            md = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : i_mode;
            if ($urandom_range(0, 3) == 0) md = 4'($urandom_range(3, 6));
            jin = {$urandom, $urandom};
            tick(($urandom_range(0, 49) == 0), md, jin, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
